pulse_timestamper: RTL
======================

Name: pulse_timestamper

Overview:
Downstream consumer of the pin capture stage (pin_capt) in the time-measurement chain. It takes the per-edge strobe, the edge level and the 3-bit fine time, and combines them with a free-running coarse counter in the clk300 domain. It pairs each rising edge with the following falling edge and produces {start timestamp, pulse width, overflow} records. Records are buffered in a small FIFO and read out through a valid/ready handshake.

Parameters:
CNT_W, 16, coarse counter width in clk300 cycles; timestamp width is TS_W = CNT_W+3.
MAX_WIDTH_CYC, 1023, pulse-width timeout in clk300 cycles (must be < 2^CNT_W - 1).
FIFO_DEPTH, 8, record FIFO depth (power of 2, >= 2).

Ports:
clk300  in  1  300 MHz system clock, the only clock.
rst  in  1  synchronous, active-high reset.
str  in  1  one-cycle strobe from pin_capt: an edge occurred in this clk300 cycle.
pin_out  in  1  pin level after the edge, valid with str (1 = rising, 0 = falling).
ptime  in  3  fine position of the edge within the cycle, 1/8 clk300 period per LSB.
out_valid  out  1  record available.
out_ready  in  1  consumer accepts the record when out_valid && out_ready.
out_start  out  TS_W  rising-edge timestamp {coarse, ptime}.
out_width  out  TS_W  pulse width in fine LSBs.
out_ovf  out  1  width saturated by timeout.
prot_err  out  1  sticky protocol error.
drop_cnt  out  8  saturating count of records lost to FIFO full.

Behaviour:
- Reset (synchronous): coarse=0, state=IDLE, FIFO empty, out_valid=0, out_start/out_width=0, out_ovf=0, prot_err=0, drop_cnt=0. Reset mid-pulse discards the partial measurement; a falling strobe after reset is handled as the IDLE falling case below.
- coarse increments every cycle and wraps modulo 2^CNT_W. Edge timestamp is ts = {coarse, ptime}, sampled in the str cycle.
- FSM states: IDLE, HIGH, WAIT_LOW.
  - IDLE:
    - str && pin_out: latch start=ts, clear timeout counter, go to HIGH.
    - str && !pin_out: ignore and set prot_err.
  - HIGH:
    - timeout counter increments each cycle.
    - str && !pin_out: width = (ts - start) mod 2^TS_W, ovf=0, push the record, go to IDLE.
    - str && pin_out (double rise): set prot_err, relatch start=ts, clear timeout counter.
    - Timeout counter reaches MAX_WIDTH_CYC with no str in that cycle: push {start, width=MAX_WIDTH_CYC*8, ovf=1}, go to WAIT_LOW.
    - str and timeout in the same cycle: str wins.
  - WAIT_LOW:
    - str && !pin_out: go to IDLE, no record.
    - str && pin_out: set prot_err, latch start=ts, go to HIGH.
- Latency: record computed in a register one cycle after the falling str, then written to the FIFO. With the FIFO empty, a falling str in cycle N gives out_valid=1 in cycle N+2. FIFO output is registered (first-word-fall-through).
- Handshake:
  - Head record holds stable while out_valid && !out_ready.
  - out_valid drops the cycle after the last record pops.
- FIFO full:
  - A push while full (with no pop in the same cycle) drops the new record; drop_cnt increments, saturating at 255.
  - Push and pop in the same cycle while full: both succeed.
  - Pop while empty: no effect.
- Width wrap: the timeout guarantees the true width is < 2^TS_W, so the modulo subtraction is exact across coarse wrap.

Decomposition:
- Package time_meas_pkg holds:
  - FINE_W=3
  - the ts_t typedef (logic [TS_W-1:0])
  - the meas_rec_t packed struct {start, width, ovf}
  - the FSM state enum.
- Sub-module ts_fifo: parameterised synchronous FIFO of meas_rec_t with full/empty, on clk300/rst. It is reused later by the readout stage.

Test Plan:
1. Rise at coarse=10/ptime=3 (ts=83), fall at coarse=14/ptime=5 (ts=117), out_ready=1 -> one record start=83, width=34, ovf=0; out_valid high exactly 2 cycles after the falling str.
2. Rise at coarse=2^CNT_W-1/ptime=6, fall 2 cycles later at coarse=1/ptime=1 -> width=11, start=(2^CNT_W-1)*8+6.
3. Rise then no fall for 1023 cycles -> record with width=8184, ovf=1. A later fall produces no record, then a normal pulse measures correctly.
4. out_ready=0, 10 back-to-back pulses -> FIFO holds 8 records in order, drop_cnt=2. Raising out_ready then drains 8 records, one per cycle.
5. Fall strobe in IDLE, and a double rise -> prot_err=1 sticky. The double rise measures width from the second rise.
6. Assert rst while in HIGH, then deliver a fall -> no record, prot_err=1, coarse restarts at 0, all outputs at reset values during rst.

Source files
------------

// File: rtl/time_meas_pkg.sv
// Shared types and constants for the time-measurement chain.
// Timestamps are {coarse clk300 count, fine 1/8-cycle position}.
package time_meas_pkg;

  // Fine-time bits delivered by pin_capt (1/8 clk300 period per LSB).
  localparam int FINE_W = 3;

  // Default coarse width; the timestamp width follows from it.
  localparam int CNT_W_DEF = 16;
  localparam int TS_W_DEF  = CNT_W_DEF + FINE_W;

  typedef logic [TS_W_DEF-1:0] ts_t;

  // One measured pulse: rising-edge timestamp, width in fine LSBs, timeout flag.
  typedef struct packed {
    ts_t  start;
    ts_t  width;
    logic ovf;
  } meas_rec_t;

  // Pulse pairing states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HIGH     = 2'd1,
    ST_WAIT_LOW = 2'd2
  } state_t;

endpackage

// File: rtl/ts_fifo.sv
// Synchronous first-word-fall-through FIFO for measurement records.
// The head entry is always visible on dout while empty is low.
// A push while full is ignored unless a pop frees a slot in the same cycle.
module ts_fifo
  import time_meas_pkg::*;
#(
  parameter type data_t = meas_rec_t,
  parameter int  DEPTH  = 8
) (
  input  logic  clk300,
  input  logic  rst,
  input  logic  push,
  input  data_t din,
  input  logic  pop,
  output data_t dout,
  output logic  full,
  output logic  empty
);

  localparam int AW = $clog2(DEPTH);

  data_t         mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          wr_en;
  logic          rd_en;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Popping an empty FIFO does nothing; a simultaneous pop makes room for a push when full.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  // Read and write pointers.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk300) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage array.
  // NOTE: memory contents are not reset; pointers define which entries are valid.
  always_ff @(posedge clk300) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/pulse_timestamper.sv
// Pairs each rising edge from pin_capt with the following falling edge and
// emits {start timestamp, width, overflow} records through a small FIFO
// with a valid/ready read port. Single clock domain (clk300).
module pulse_timestamper
  import time_meas_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter int MAX_WIDTH_CYC = 1023,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                    clk300,
  input  logic                    rst,
  input  logic                    str,
  input  logic                    pin_out,
  input  logic [FINE_W-1:0]       ptime,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_W+FINE_W-1:0] out_start,
  output logic [CNT_W+FINE_W-1:0] out_width,
  output logic                    out_ovf,
  output logic                    prot_err,
  output logic [7:0]              drop_cnt
);

  localparam int TS_W  = CNT_W + FINE_W;
  localparam int TMO_W = $clog2(MAX_WIDTH_CYC + 1);

  // Width reported for a timed-out pulse, in fine LSBs.
  localparam logic [TS_W-1:0]  OVF_WIDTH = TS_W'(MAX_WIDTH_CYC) << FINE_W;
  // Counter value in the cycle where the pulse has lasted MAX_WIDTH_CYC cycles.
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(MAX_WIDTH_CYC - 1);

  typedef struct packed {
    logic [TS_W-1:0] start;
    logic [TS_W-1:0] width;
    logic            ovf;
  } rec_t;

  logic [CNT_W-1:0] coarse;
  logic [TS_W-1:0]  ts;

  state_t           state_q,  state_d;
  logic [TS_W-1:0]  start_q,  start_d;
  logic [TMO_W-1:0] tmo_q,    tmo_d;
  rec_t             rec_q,    rec_d;
  logic             rec_push_q, rec_push_d;
  logic             perr_set;

  rec_t             head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             drop;

  // Free-running coarse time base, wraps modulo 2^CNT_W.
  always_ff @(posedge clk300) begin
    if (rst) coarse <= '0;
    else     coarse <= coarse + CNT_W'(1);
  end

  assign ts = {coarse, ptime};

  // Pairing FSM: state, start latch, timeout counter and the record stage.
  always_ff @(posedge clk300) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      start_q    <= '0;
      tmo_q      <= '0;
      rec_q      <= '0;
      rec_push_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      tmo_q      <= tmo_d;
      rec_q      <= rec_d;
      rec_push_q <= rec_push_d;
    end
  end

  // Next-state and record formation; a strobe always takes priority over the timeout.
  // NOTE: every output of this block gets a default first, so no latches are inferred.
  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    tmo_d      = tmo_q;
    rec_d      = rec_q;
    rec_push_d = 1'b0;
    perr_set   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (str) begin
          if (pin_out) begin
            start_d = ts;
            tmo_d   = '0;
            state_d = ST_HIGH;
          end else begin
            perr_set = 1'b1;
          end
        end
      end

      ST_HIGH: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (str && !pin_out) begin
          // The timeout bounds the width below 2^TS_W, so modulo subtraction is exact.
          rec_d.start = start_q;
          rec_d.width = ts - start_q;
          rec_d.ovf   = 1'b0;
          rec_push_d  = 1'b1;
          state_d     = ST_IDLE;
        end else if (str) begin
          // Double rise: measure from the most recent rising edge.
          perr_set = 1'b1;
          start_d  = ts;
          tmo_d    = '0;
        end else if (tmo_q == TMO_LAST) begin
          rec_d.start = start_q;
          rec_d.width = OVF_WIDTH;
          rec_d.ovf   = 1'b1;
          rec_push_d  = 1'b1;
          state_d     = ST_WAIT_LOW;
        end
      end

      ST_WAIT_LOW: begin
        if (str) begin
          if (pin_out) begin
            perr_set = 1'b1;
            start_d  = ts;
            tmo_d    = '0;
            state_d  = ST_HIGH;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  ts_fifo #(
    .data_t (rec_t),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk300 (clk300),
    .rst    (rst),
    .push   (rec_push_q),
    .din    (rec_q),
    .pop    (pop),
    .dout   (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign drop      = rec_push_q && fifo_full && !pop;

  // Record fields read as zero while nothing is queued, so reset values are clean.
  assign out_start = fifo_empty ? '0   : head.start;
  assign out_width = fifo_empty ? '0   : head.width;
  assign out_ovf   = fifo_empty ? 1'b0 : head.ovf;

  // Sticky protocol-error flag.
  always_ff @(posedge clk300) begin
    if (rst)           prot_err <= 1'b0;
    else if (perr_set) prot_err <= 1'b1;
  end

  // Saturating count of records lost to a full FIFO.
  always_ff @(posedge clk300) begin
    if (rst)                           drop_cnt <= '0;
    else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end

endmodule
